// File: rtl/ssd_scan_decoder_pkg.sv
// Shared definitions for the seven-segment scan decoder.
// Holds the active-low segment patterns, the decoded code values, the anode
// one-hot patterns, the FSM state type and a helper that maps an anode
// pattern to a digit slot index.
package ssd_scan_decoder_pkg;

    // Segment patterns, active-low, bit order {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] CODE_BLANK = 4'hA;
    localparam logic [3:0] CODE_BAD   = 4'hF;

    // Anode patterns, active-low, AN[3] is the leftmost digit
    localparam logic [3:0] AN_D3   = 4'b0111;
    localparam logic [3:0] AN_D2   = 4'b1011;
    localparam logic [3:0] AN_D1   = 4'b1101;
    localparam logic [3:0] AN_D0   = 4'b1110;
    localparam logic [3:0] AN_NONE = 4'b1111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    typedef struct packed {
        logic       hit;  // exactly one anode low
        logic [1:0] idx;  // slot index of that anode
    } an_dec_t;

    // Map a one-hot-low anode pattern to its slot; hit=0 for anything else.
    function automatic an_dec_t an_decode(input logic [3:0] an);
        an_dec_t r;
        r.hit = 1'b1;
        r.idx = 2'd0;
        case (an)
            AN_D3:   r.idx = 2'd3;
            AN_D2:   r.idx = 2'd2;
            AN_D1:   r.idx = 2'd1;
            AN_D0:   r.idx = 2'd0;
            default: r.hit = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ssd_scan_decoder_if.sv
// Scanned display bus plus decoded results.
// master: drives AN/C (display driver or bench), observes the results.
// slave : the decoder, samples AN/C and drives the results.
//   AN[3:0]     anode enables, active-low
//   C[6:0]      segments, active-low, C[6]=a .. C[0]=g
//   digits      last complete frame {d3,d2,d1,d0}
//   frame_valid one-cycle pulse when digits updates
//   seg_err     one-cycle pulse, captured pattern not decodable
//   an_err      one-cycle pulse, settled AN with more than one bit low
//   stale       level, no capture for the timeout period
interface ssd_scan_decoder_if;
    logic [3:0]  AN;
    logic [6:0]  C;
    logic [15:0] digits;
    logic        frame_valid;
    logic        seg_err;
    logic        an_err;
    logic        stale;

    modport master (
        output AN, C,
        input  digits, frame_valid, seg_err, an_err, stale
    );

    modport slave (
        input  AN, C,
        output digits, frame_valid, seg_err, an_err, stale
    );
endinterface

// File: rtl/ssd_scan_decoder_seg_to_hex.sv
// Combinational inverse of the seven-segment driver table.
//   seg_i[6:0]   active-low segment pattern {a..g}
//   code_c_o     decoded code: 0-9, 4'hA for blank, 4'hF for unknown
//   bad_c_o      high when the pattern is not in the table
module ssd_scan_decoder_seg_to_hex
    import ssd_scan_decoder_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] code_c_o,
    output logic       bad_c_o
);

    always_comb begin
        code_c_o = CODE_BAD;
        bad_c_o  = 1'b0;
        case (seg_i)
            SEG_0:     code_c_o = 4'h0;
            SEG_1:     code_c_o = 4'h1;
            SEG_2:     code_c_o = 4'h2;
            SEG_3:     code_c_o = 4'h3;
            SEG_4:     code_c_o = 4'h4;
            SEG_5:     code_c_o = 4'h5;
            SEG_6:     code_c_o = 4'h6;
            SEG_7:     code_c_o = 4'h7;
            SEG_8:     code_c_o = 4'h8;
            SEG_9:     code_c_o = 4'h9;
            SEG_BLANK: code_c_o = CODE_BLANK;
            default:   bad_c_o  = 1'b1;
        endcase
    end

endmodule

// File: rtl/ssd_scan_decoder.sv
// Receive-side monitor for a 4-digit multiplexed seven-segment bus.
// Synchronizes AN/C, waits for each digit dwell to settle, captures one
// decoded nibble per dwell and emits a frame once all four slots are seen.
//   clock  system clock
//   reset  asynchronous active-low reset
//   bus    slave side of ssd_scan_decoder_if (AN/C in, results out)
module ssd_scan_decoder
    import ssd_scan_decoder_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                clock,
    input  logic                reset,
    ssd_scan_decoder_if.slave   bus
);

    localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] CNT_FIRE = CW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] T_MAX    = TW'(TIMEOUT_CYCLES);

    logic [3:0]       an_m_q, an_s_q;
    logic [6:0]       c_m_q, c_s_q;
    logic [10:0]      s_prev_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    state_t           state_q, state_d;
    logic [3:0][3:0]  slot_q, slot_d;
    logic [3:0]       seen_q, seen_d;
    logic [15:0]      digits_q, digits_d;
    logic             fv_q, fv_d;
    logic             seg_err_q, seg_err_d;
    logic             an_err_q, an_err_d;
    logic             stale_q, stale_d;

    logic             same_c;
    logic             capture_c;
    logic [3:0]       code_c;
    logic             bad_c;
    an_dec_t          adec_c;

    // Two-flop synchronizers; idle bus value on reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            an_m_q <= AN_NONE;
            an_s_q <= AN_NONE;
            c_m_q  <= SEG_BLANK;
            c_s_q  <= SEG_BLANK;
        end else begin
            an_m_q <= bus.AN;
            an_s_q <= an_m_q;
            c_m_q  <= bus.C;
            c_s_q  <= c_m_q;
        end
    end

    assign same_c = ({an_s_q, c_s_q} == s_prev_q);

    ssd_scan_decoder_seg_to_hex u_seg_to_hex (
        .seg_i    (c_s_q),
        .code_c_o (code_c),
        .bad_c_o  (bad_c)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Dwell tracking: one capture per settled dwell, then hold until the bus moves
    always_comb begin
        state_d   = state_q;
        capture_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (an_s_q != AN_NONE) state_d = SETTLE;
            end
            SETTLE: begin
                if (an_s_q == AN_NONE) begin
                    state_d = IDLE;
                end else if (same_c && (cnt_q == CNT_FIRE)) begin
                    capture_c = 1'b1;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (!same_c) state_d = (an_s_q == AN_NONE) ? IDLE : SETTLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Slot write, frame assembly, error pulses and timeout
    always_comb begin
        adec_c    = an_decode(an_s_q);
        cnt_d     = same_c ? ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1)) : '0;
        tcnt_d    = (tcnt_q == T_MAX) ? tcnt_q : tcnt_q + TW'(1);
        slot_d    = slot_q;
        seen_d    = seen_q;
        digits_d  = digits_q;
        fv_d      = 1'b0;
        seg_err_d = 1'b0;
        an_err_d  = 1'b0;
        if (capture_c) begin
            tcnt_d = '0;
            if (adec_c.hit) begin
                slot_d[adec_c.idx] = code_c;
                seen_d[adec_c.idx] = 1'b1;
                seg_err_d          = bad_c;
            end else begin
                an_err_d = 1'b1;
            end
            // Completing capture publishes the frame including its own nibble
            if (seen_d == 4'b1111) begin
                digits_d = slot_d;
                fv_d     = 1'b1;
                seen_d   = '0;
            end
        end
        stale_d = (tcnt_d == T_MAX);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s_prev_q  <= {AN_NONE, SEG_BLANK};
            cnt_q     <= '0;
            tcnt_q    <= '0;
            slot_q    <= {4{CODE_BLANK}};
            seen_q    <= '0;
            digits_q  <= {4{CODE_BLANK}};
            fv_q      <= 1'b0;
            seg_err_q <= 1'b0;
            an_err_q  <= 1'b0;
            stale_q   <= 1'b0;
        end else begin
            s_prev_q  <= {an_s_q, c_s_q};
            cnt_q     <= cnt_d;
            tcnt_q    <= tcnt_d;
            slot_q    <= slot_d;
            seen_q    <= seen_d;
            digits_q  <= digits_d;
            fv_q      <= fv_d;
            seg_err_q <= seg_err_d;
            an_err_q  <= an_err_d;
            stale_q   <= stale_d;
        end
    end

    assign bus.digits      = digits_q;
    assign bus.frame_valid = fv_q;
    assign bus.seg_err     = seg_err_q;
    assign bus.an_err      = an_err_q;
    assign bus.stale       = stale_q;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Directed bench for ssd_scan_decoder with a frame scoreboard.
module tb_ssd_scan_decoder;
    import ssd_scan_decoder_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ssd_scan_decoder_if bus();

    ssd_scan_decoder #(
        .SETTLE_CYCLES  (4),
        .TIMEOUT_CYCLES (100)
    ) u_dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int fv_cnt      = 0;
    int seg_cnt     = 0;
    int an_cnt      = 0;
    logic [15:0] exp_q[$];
    int          fv_t[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.frame_valid) begin
                fv_cnt++;
                fv_t.push_back(cyc);
                if (exp_q.size() == 0) check("fv_unexpected", 32'(bus.frame_valid), 32'd0);
                else                   check("digits", 32'(bus.digits), 32'(exp_q.pop_front()));
            end
            if (bus.seg_err) seg_cnt++;
            if (bus.an_err)  an_cnt++;
        end
    end

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dwell(input logic [3:0] an, input logic [6:0] c, input int n);
        bus.AN = an;
        bus.C  = c;
        repeat (n) step();
    endtask

    task automatic scan(input logic [15:0] d);
        dwell(4'b0111, seg_of(d[15:12]), 8);
        dwell(4'b1011, seg_of(d[11:8]),  8);
        dwell(4'b1101, seg_of(d[7:4]),   8);
        dwell(4'b1110, seg_of(d[3:0]),   8);
    endtask

    task automatic idle(input int n);
        dwell(4'b1111, 7'b1111111, n);
    endtask

    initial begin
        int f0, s0, a0, t0, n;
        bus.AN = 4'b1111;
        bus.C  = 7'b1111111;
        rst_n  = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_digits", 32'(bus.digits), 32'h0000AAAA);
        check("rst_fv",     32'(bus.frame_valid), 32'd0);
        check("rst_seg_err", 32'(bus.seg_err), 32'd0);
        check("rst_an_err", 32'(bus.an_err), 32'd0);
        check("rst_stale",  32'(bus.stale), 32'd0);
        rst_n = 1'b1;
        step();

        // 1,2,3,4 scan plus final-digit latency
        f0 = fv_cnt; s0 = seg_cnt; a0 = an_cnt;
        exp_q.push_back(16'h1234);
        dwell(4'b0111, 7'b1001111, 8);
        dwell(4'b1011, 7'b0010010, 8);
        dwell(4'b1101, 7'b0000110, 8);
        t0 = cyc;
        dwell(4'b1110, 7'b1001100, 8);
        idle(4);
        check("t1_frames", 32'(fv_cnt - f0), 32'd1);
        check("t1_latency", 32'(fv_t[fv_t.size()-1] - t0), 32'd7);
        check("t1_seg_err", 32'(seg_cnt - s0), 32'd0);
        check("t1_an_err",  32'(an_cnt - a0), 32'd0);

        // Repeated blank,blank,5,9 scans
        f0 = fv_cnt;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(16'hAA59);
            scan(16'hAA59);
        end
        idle(4);
        n = fv_t.size();
        check("t2_frames", 32'(fv_cnt - f0), 32'd3);
        check("t2_spacing_a", 32'(fv_t[n-1] - fv_t[n-2]), 32'd32);
        check("t2_spacing_b", 32'(fv_t[n-2] - fv_t[n-3]), 32'd32);

        // Short slot-0 dwell is ignored; second pass overwrites seen slots
        f0 = fv_cnt;
        dwell(4'b0111, seg_of(4'h9), 8);
        dwell(4'b1011, seg_of(4'h9), 8);
        dwell(4'b1101, seg_of(4'h9), 8);
        dwell(4'b1110, seg_of(4'h4), 3);
        dwell(4'b0111, seg_of(4'h7), 8);
        dwell(4'b1011, seg_of(4'h3), 8);
        dwell(4'b1101, seg_of(4'h0), 8);
        check("t3_no_frame", 32'(fv_cnt - f0), 32'd0);
        exp_q.push_back(16'h7301);
        dwell(4'b1110, seg_of(4'h1), 8);
        idle(4);
        check("t3_frames", 32'(fv_cnt - f0), 32'd1);

        // Undecodable pattern in slot 2
        f0 = fv_cnt; s0 = seg_cnt;
        exp_q.push_back(16'h2F46);
        dwell(4'b0111, seg_of(4'h2), 8);
        dwell(4'b1011, 7'b1111110, 8);
        dwell(4'b1101, seg_of(4'h4), 8);
        dwell(4'b1110, seg_of(4'h6), 8);
        idle(4);
        check("t4_frames",  32'(fv_cnt - f0), 32'd1);
        check("t4_seg_err", 32'(seg_cnt - s0), 32'd1);

        // Two anodes low mid-frame: error, no slot write
        f0 = fv_cnt; a0 = an_cnt; s0 = seg_cnt;
        exp_q.push_back(16'h5678);
        dwell(4'b0111, seg_of(4'h5), 8);
        dwell(4'b1011, seg_of(4'h6), 8);
        dwell(4'b0011, seg_of(4'h8), 8);
        check("t5_an_err", 32'(an_cnt - a0), 32'd1);
        check("t5_no_frame", 32'(fv_cnt - f0), 32'd0);
        dwell(4'b1101, seg_of(4'h7), 8);
        dwell(4'b1110, seg_of(4'h8), 8);
        idle(4);
        check("t5_frames",  32'(fv_cnt - f0), 32'd1);
        check("t5_seg_err", 32'(seg_cnt - s0), 32'd0);

        // Reset after a partial frame
        f0 = fv_cnt;
        dwell(4'b0111, seg_of(4'h1), 8);
        dwell(4'b1011, seg_of(4'h1), 8);
        dwell(4'b1101, seg_of(4'h1), 8);
        bus.AN = 4'b1111;
        bus.C  = 7'b1111111;
        rst_n  = 1'b0;
        repeat (3) step();
        check("t6_rst_digits", 32'(bus.digits), 32'h0000AAAA);
        rst_n = 1'b1;
        step();
        exp_q.push_back(16'h6780);
        scan(16'h6780);
        idle(4);
        check("t6_frames", 32'(fv_cnt - f0), 32'd1);
        check("t6_digits_hold", 32'(bus.digits), 32'h00006780);

        // Stale timeout from reset with an idle bus, cleared by a capture
        rst_n = 1'b0;
        step();
        check("t7_stale_rst", 32'(bus.stale), 32'd0);
        rst_n = 1'b1;
        repeat (99) step();
        check("t7_stale_99", 32'(bus.stale), 32'd0);
        step();
        check("t7_stale_100", 32'(bus.stale), 32'd1);
        dwell(4'b0111, seg_of(4'h3), 6);
        check("t7_stale_before_cap", 32'(bus.stale), 32'd1);
        dwell(4'b0111, seg_of(4'h3), 2);
        check("t7_stale_cleared", 32'(bus.stale), 32'd0);

        idle(4);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
